seg_pair_decoder: RTL and testbench

SEG_PAIR_DECODER -- requirements
Module: seg_pair_decoder

---
 rtl/seg_pkg.sv | 44 ++++
 rtl/seg7_to_bcd.sv | 29 ++
 rtl/seg_pair_decoder.sv | 127 ++++++++++++
 tb/tb_seg_pair_decoder.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment constants, display bus layout and tracker FSM encoding.
// Also used by the counter side, so keep it free of decoder-specific logic.
package seg_pkg;

   localparam int unsigned SEG_W   = 7;
   localparam int unsigned TAG_W   = 2;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned VAL_W   = 7;

   // gfedcba patterns for digits 0..9
   localparam logic [SEG_W-1:0] SEG_0 = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1 = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2 = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3 = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4 = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5 = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6 = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7 = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8 = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9 = 7'h6F;

   localparam logic [TAG_W-1:0] TAG_TENS  = 2'b01;
   localparam logic [TAG_W-1:0] TAG_UNITS = 2'b00;

   localparam logic [VAL_W-1:0] VAL_MAX = 7'd99;

   typedef struct packed {
      logic [TAG_W-1:0] tag;
      logic [SEG_W-1:0] seg;
   } seg_bus_t;

   typedef enum logic [1:0] {
      S_INIT  = 2'd0,
      S_TRACK = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   // Two BCD digits to their 0..99 value
   function automatic logic [VAL_W-1:0] bcd_value(input logic [DIGIT_W-1:0] shi,
                                                  input logic [DIGIT_W-1:0] ge);
      return VAL_W'(VAL_W'(shi) * 7'd10) + VAL_W'(ge);
   endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational seven-segment pattern to BCD digit decoder; ok_c low on any
// pattern that is not one of the ten digit shapes.
module seg7_to_bcd
   import seg_pkg::*;
(
   input  logic [SEG_W-1:0]   seg,
   output logic [DIGIT_W-1:0] digit_c,
   output logic               ok_c
);

   always_comb begin
      digit_c = '0;
      ok_c    = 1'b1;
      case (seg)
         SEG_0:   digit_c = 4'd0;
         SEG_1:   digit_c = 4'd1;
         SEG_2:   digit_c = 4'd2;
         SEG_3:   digit_c = 4'd3;
         SEG_4:   digit_c = 4'd4;
         SEG_5:   digit_c = 4'd5;
         SEG_6:   digit_c = 4'd6;
         SEG_7:   digit_c = 4'd7;
         SEG_8:   digit_c = 4'd8;
         SEG_9:   digit_c = 4'd9;
         default: ok_c    = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_pair_decoder.sv
// Debounces a two-digit seven-segment display, commits stable readings and
// classifies each committed change as step, wrap, clear or sequence fault.
module seg_pair_decoder
   import seg_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [TAG_W+SEG_W-1:0]   seg_led_1,
   input  logic [TAG_W+SEG_W-1:0]   seg_led_2,
   input  logic                     clr_err,
   output logic [DIGIT_W-1:0]       digit_shi,
   output logic [DIGIT_W-1:0]       digit_ge,
   output logic                     valid,
   output logic                     step_pulse,
   output logic                     wrap_pulse,
   output logic                     clear_pulse,
   output logic [15:0]              step_count,
   output logic                     err
);

   localparam int unsigned CNT_W = 4;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

   seg_bus_t          tens_q, units_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              judged_q;
   state_t            state_q, state_d;

   logic [DIGIT_W-1:0] tens_dig_c, units_dig_c;
   logic               tens_ok_c, units_ok_c;
   logic               in_diff_c, samp_ok_c, eval_c, commit_c, bad_samp_c;
   logic               is_step_c, is_wrap_c, is_clear_c, classify_c, seq_err_c, err_evt_c;
   logic [VAL_W-1:0]   old_v_c, new_v_c;
   logic               step_d, wrap_d, clear_d, err_d;

   seg7_to_bcd u_tens  (.seg(tens_q.seg),  .digit_c(tens_dig_c),  .ok_c(tens_ok_c));
   seg7_to_bcd u_units (.seg(units_q.seg), .digit_c(units_dig_c), .ok_c(units_ok_c));

   // Sample qualification and commit classification
   always_comb begin
      in_diff_c  = {seg_led_1, seg_led_2} != {tens_q, units_q};
      samp_ok_c  = tens_ok_c && units_ok_c &&
                   (tens_q.tag == TAG_TENS) && (units_q.tag == TAG_UNITS);
      eval_c     = (cnt_q == CNT_MAX) && !judged_q;
      old_v_c    = bcd_value(digit_shi, digit_ge);
      new_v_c    = bcd_value(tens_dig_c, units_dig_c);
      commit_c   = eval_c && samp_ok_c && (!valid || (new_v_c != old_v_c));
      bad_samp_c = eval_c && !samp_ok_c;
      is_step_c  = new_v_c == (old_v_c + 7'd1);
      is_wrap_c  = (old_v_c == VAL_MAX) && (new_v_c == '0);
      is_clear_c = (new_v_c == '0) && !is_wrap_c;
      classify_c = commit_c && valid;
      seq_err_c  = classify_c && !(is_step_c || is_wrap_c || is_clear_c);
      err_evt_c  = bad_samp_c || seq_err_c;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_INIT;
      else     state_q <= state_d;
   end

   // A fresh error on the clearing edge keeps the fault
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_INIT: begin
            if (err_evt_c)     state_d = S_FAULT;
            else if (commit_c) state_d = S_TRACK;
         end
         S_TRACK: begin
            if (err_evt_c) state_d = S_FAULT;
         end
         S_FAULT: begin
            if (!err_evt_c && clr_err) state_d = (valid || commit_c) ? S_TRACK : S_INIT;
         end
         default: state_d = S_INIT;
      endcase
   end

   always_comb begin
      step_d  = classify_c && (is_step_c || is_wrap_c);
      wrap_d  = classify_c && is_wrap_c;
      clear_d = classify_c && is_clear_c;
      err_d   = state_d == S_FAULT;
   end

   // Sample register, stability window and committed outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tens_q      <= '0;
         units_q     <= '0;
         cnt_q       <= '0;
         judged_q    <= 1'b0;
         digit_shi   <= '0;
         digit_ge    <= '0;
         valid       <= 1'b0;
         step_pulse  <= 1'b0;
         wrap_pulse  <= 1'b0;
         clear_pulse <= 1'b0;
         step_count  <= '0;
         err         <= 1'b0;
      end else begin
         tens_q  <= seg_bus_t'(seg_led_1);
         units_q <= seg_bus_t'(seg_led_2);
         if (in_diff_c) begin
            cnt_q    <= '0;
            judged_q <= 1'b0;
         end else begin
            if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
            if (eval_c)           judged_q <= 1'b1;
         end
         if (commit_c) begin
            digit_shi <= tens_dig_c;
            digit_ge  <= units_dig_c;
            valid     <= 1'b1;
         end
         step_pulse  <= step_d;
         wrap_pulse  <= wrap_d;
         clear_pulse <= clear_d;
         err         <= err_d;
         if (step_d) step_count <= step_count + 16'd1;
      end
   end

endmodule

// File: tb/tb_seg_pair_decoder.sv
// Directed bench for seg_pair_decoder at the default stability window of 4.
module tb_seg_pair_decoder;

   logic        clk = 1'b0;
   logic        rst;
   logic [8:0]  seg_led_1, seg_led_2;
   logic        clr_err;
   logic [3:0]  digit_shi, digit_ge;
   logic        valid, step_pulse, wrap_pulse, clear_pulse, err;
   logic [15:0] step_count;

   int total = 0;
   int bad = 0;
   int pulse_seen = 0;

   always #5 clk = ~clk;

   seg_pair_decoder #(.STABLE_CYCLES(4)) dut (
      .clk(clk), .rst(rst), .seg_led_1(seg_led_1), .seg_led_2(seg_led_2),
      .clr_err(clr_err), .digit_shi(digit_shi), .digit_ge(digit_ge), .valid(valid),
      .step_pulse(step_pulse), .wrap_pulse(wrap_pulse), .clear_pulse(clear_pulse),
      .step_count(step_count), .err(err)
   );

   function automatic logic [6:0] pat(input int d);
      case (d)
         0: return 7'h3F; 1: return 7'h06; 2: return 7'h5B; 3: return 7'h4F;
         4: return 7'h66; 5: return 7'h6D; 6: return 7'h7D; 7: return 7'h07;
         8: return 7'h7F; 9: return 7'h6F;
         default: return 7'h00;
      endcase
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (step_pulse || wrap_pulse || clear_pulse) pulse_seen++;
   endtask

   task automatic drive(input int s, input int g);
      seg_led_1 = {2'b01, pat(s)};
      seg_led_2 = {2'b00, pat(g)};
   endtask

   task automatic do_reset(input int s, input int g);
      rst = 1'b1;
      clr_err = 1'b0;
      drive(s, g);
      #2;
      @(negedge clk);
      rst = 1'b0;
      pulse_seen = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clr_err = 1'b0;
      drive(0, 0);
      #12;
      total++;
      if ({digit_shi, digit_ge, valid, step_pulse, wrap_pulse, clear_pulse, step_count, err} !== 31'd0) begin
         bad++;
         $display("FAIL reset_outputs: got shi=%0d ge=%0d v=%b p=%b%b%b cnt=%0d err=%b want all zero",
                  digit_shi, digit_ge, valid, step_pulse, wrap_pulse, clear_pulse, step_count, err);
      end
   endtask

   task automatic test_first_commit();
      do_reset(0, 0);
      repeat (4) tick();
      total++;
      if (valid !== 1'b0) begin bad++; $display("FAIL first_commit_early: valid got %b want 0", valid); end
      tick();
      total++;
      if ({valid, digit_shi, digit_ge, err} !== 10'b1_0000_0000_0 || pulse_seen != 0) begin
         bad++;
         $display("FAIL first_commit: valid=%b shi=%0d ge=%0d err=%b pulses=%0d want 1 0 0 0 0",
                  valid, digit_shi, digit_ge, err, pulse_seen);
      end
   endtask

   task automatic test_steps();
      for (int u = 1; u <= 9; u++) begin
         drive(0, u);
         repeat (5) tick();
         total++;
         if ({step_pulse, wrap_pulse, clear_pulse} !== 3'b100 || digit_ge !== 4'(u)) begin
            bad++;
            $display("FAIL step_units: pulses got %b%b%b ge=%0d want 100 ge=%0d",
                     step_pulse, wrap_pulse, clear_pulse, digit_ge, u);
         end
      end
      drive(1, 0);
      repeat (5) tick();
      total++;
      if ({step_pulse, wrap_pulse, clear_pulse} !== 3'b100) begin
         bad++;
         $display("FAIL step_tens: pulses got %b%b%b want 100", step_pulse, wrap_pulse, clear_pulse);
      end
      total++;
      if (step_count !== 16'd10 || digit_shi !== 4'd1 || digit_ge !== 4'd0 || err !== 1'b0 || pulse_seen != 10) begin
         bad++;
         $display("FAIL step_summary: cnt=%0d shi=%0d ge=%0d err=%b pulses=%0d want 10 1 0 0 10",
                  step_count, digit_shi, digit_ge, err, pulse_seen);
      end
   endtask

   task automatic test_wrap_clear();
      do_reset(9, 9);
      repeat (5) tick();
      drive(0, 0);
      repeat (5) tick();
      total++;
      if ({step_pulse, wrap_pulse, clear_pulse} !== 3'b110 || step_count !== 16'd1 || err !== 1'b0) begin
         bad++;
         $display("FAIL wrap: pulses got %b%b%b cnt=%0d err=%b want 110 1 0",
                  step_pulse, wrap_pulse, clear_pulse, step_count, err);
      end
      tick();
      total++;
      if ({step_pulse, wrap_pulse, clear_pulse} !== 3'b000) begin
         bad++;
         $display("FAIL pulse_width: pulses got %b%b%b want 000", step_pulse, wrap_pulse, clear_pulse);
      end
      do_reset(4, 7);
      repeat (5) tick();
      drive(0, 0);
      repeat (5) tick();
      total++;
      if ({step_pulse, wrap_pulse, clear_pulse} !== 3'b001 || step_count !== 16'd0 ||
          digit_shi !== 4'd0 || digit_ge !== 4'd0 || err !== 1'b0) begin
         bad++;
         $display("FAIL clear: pulses got %b%b%b cnt=%0d shi=%0d ge=%0d err=%b want 001 0 0 0 0",
                  step_pulse, wrap_pulse, clear_pulse, step_count, digit_shi, digit_ge, err);
      end
   endtask

   task automatic test_bounce();
      do_reset(2, 3);
      repeat (5) tick();
      pulse_seen = 0;
      for (int i = 0; i < 5; i++) begin
         seg_led_2 = {2'b00, 7'h4F};
         repeat (2) tick();
         seg_led_2 = {2'b00, 7'h66};
         repeat (2) tick();
      end
      total++;
      if (pulse_seen != 0 || digit_shi !== 4'd2 || digit_ge !== 4'd3) begin
         bad++;
         $display("FAIL bounce_hold_off: pulses=%0d shi=%0d ge=%0d want 0 2 3", pulse_seen, digit_shi, digit_ge);
      end
      repeat (3) tick();
      total++;
      if (step_pulse !== 1'b1 || pulse_seen != 1 || digit_shi !== 4'd2 || digit_ge !== 4'd4 || step_count !== 16'd1) begin
         bad++;
         $display("FAIL bounce_settle: step=%b pulses=%0d shi=%0d ge=%0d cnt=%0d want 1 1 2 4 1",
                  step_pulse, pulse_seen, digit_shi, digit_ge, step_count);
      end
   endtask

   task automatic test_errors();
      do_reset(2, 3);
      repeat (5) tick();
      drive(2, 5);
      repeat (5) tick();
      total++;
      if (err !== 1'b1 || digit_shi !== 4'd2 || digit_ge !== 4'd5 || {step_pulse, wrap_pulse, clear_pulse} !== 3'b000) begin
         bad++;
         $display("FAIL seq_error: err=%b shi=%0d ge=%0d pulses=%b%b%b want 1 2 5 000",
                  err, digit_shi, digit_ge, step_pulse, wrap_pulse, clear_pulse);
      end
      seg_led_2 = {2'b00, 7'h49};
      repeat (6) tick();
      total++;
      if (err !== 1'b1 || digit_shi !== 4'd2 || digit_ge !== 4'd5) begin
         bad++;
         $display("FAIL bad_pattern: err=%b shi=%0d ge=%0d want 1 2 5", err, digit_shi, digit_ge);
      end
      clr_err = 1'b1;
      tick();
      clr_err = 1'b0;
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL clr_err: err got %b want 0", err); end
      drive(2, 6);
      repeat (5) tick();
      total++;
      if (step_pulse !== 1'b1 || err !== 1'b0 || digit_ge !== 4'd6) begin
         bad++;
         $display("FAIL track_after_clear: step=%b err=%b ge=%0d want 1 0 6", step_pulse, err, digit_ge);
      end
   endtask

   task automatic test_tag_and_reset();
      do_reset(0, 0);
      seg_led_1 = {2'b11, 7'h3F};
      repeat (4) tick();
      total++;
      if (err !== 1'b0) begin bad++; $display("FAIL tag_early: err got %b want 0", err); end
      repeat (2) tick();
      total++;
      if (err !== 1'b1 || valid !== 1'b0) begin
         bad++;
         $display("FAIL bad_tag: err=%b valid=%b want 1 0", err, valid);
      end
      drive(0, 0);
      repeat (2) tick();
      rst = 1'b1;
      #1;
      total++;
      if ({digit_shi, digit_ge, valid, step_pulse, wrap_pulse, clear_pulse, step_count, err} !== 31'd0) begin
         bad++;
         $display("FAIL async_reset: shi=%0d ge=%0d v=%b p=%b%b%b cnt=%0d err=%b want all zero",
                  digit_shi, digit_ge, valid, step_pulse, wrap_pulse, clear_pulse, step_count, err);
      end
      @(negedge clk);
      rst = 1'b0;
      pulse_seen = 0;
      repeat (5) tick();
      total++;
      if (valid !== 1'b1 || pulse_seen != 0 || err !== 1'b0 || step_count !== 16'd0) begin
         bad++;
         $display("FAIL resume: valid=%b pulses=%0d err=%b cnt=%0d want 1 0 0 0", valid, pulse_seen, err, step_count);
      end
   endtask

   initial begin
      test_reset();
      test_first_commit();
      test_steps();
      test_wrap_clear();
      test_bounce();
      test_errors();
      test_tag_and_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
